banco_registradores: RTL and testbench

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

---
 rtl/banco_registradores_pkg.sv | 8 +
 rtl/porta_leitura_bypass.sv | 29 ++
 rtl/banco_registradores.sv | 68 ++++++
 tb/tb_banco_registradores.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_pkg.sv
// Shared processor constants for the register file: data width, register count,
// address width and write-counter width.
package banco_registradores_pkg;
    localparam int LARGURA_DADOS_PADRAO = 32;
    localparam int NUM_REGS_PADRAO      = 32;
    localparam int LARGURA_ENDERECO     = 5;
    localparam int LARGURA_CONTADOR     = 16;
endpackage

// File: rtl/porta_leitura_bypass.sv
// One combinational read port: register 0 reads zero, a same-cycle write to the
// addressed register is forwarded, and everything reads zero while reset is held.
module porta_leitura_bypass
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA_DADOS = LARGURA_DADOS_PADRAO,
    parameter int NUM_REGS      = NUM_REGS_PADRAO
) (
    input  logic                                    i_reset_n,
    input  logic [NUM_REGS-1:0][LARGURA_DADOS-1:0] i_regs,
    input  logic                                    i_escrita_valida,
    input  logic [LARGURA_ENDERECO-1:0]             i_endereco_escrita,
    input  logic [LARGURA_DADOS-1:0]                i_dado_escrita,
    input  logic [LARGURA_ENDERECO-1:0]             i_endereco_leitura,
    output logic [LARGURA_DADOS-1:0]                o_dado_leitura
);

    always_comb begin
        o_dado_leitura = '0;
        // Reset must mask the bypass too, since the write data is still live on the bus
        if (!i_reset_n || i_endereco_leitura == '0)
            o_dado_leitura = '0;
        else if (i_escrita_valida && i_endereco_leitura == i_endereco_escrita)
            o_dado_leitura = i_dado_escrita;
        else
            o_dado_leitura = i_regs[i_endereco_leitura];
    end

endmodule

// File: rtl/banco_registradores.sv
// Flip-flop register file with two bypassed combinational read ports, a registered
// debug read port and a wrapping count of accepted writes.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA_DADOS = LARGURA_DADOS_PADRAO,
    parameter int NUM_REGS      = NUM_REGS_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [LARGURA_ENDERECO-1:0] endereco_escrita,
    input  logic [LARGURA_DADOS-1:0]    dado_escrita,
    input  logic                        escrita_habilitada,
    input  logic [LARGURA_ENDERECO-1:0] endereco_leitura_a,
    input  logic [LARGURA_ENDERECO-1:0] endereco_leitura_b,
    output logic [LARGURA_DADOS-1:0]    dado_leitura_a,
    output logic [LARGURA_DADOS-1:0]    dado_leitura_b,
    input  logic [LARGURA_ENDERECO-1:0] endereco_depuracao,
    output logic [LARGURA_DADOS-1:0]    dado_depuracao,
    output logic [LARGURA_CONTADOR-1:0] contador_escritas
);

    logic [NUM_REGS-1:0][LARGURA_DADOS-1:0] r_regs;
    logic [LARGURA_DADOS-1:0]               r_dado_depuracao;
    logic [LARGURA_CONTADOR-1:0]            r_contador;
    logic                                   w_escrita_valida;

    assign w_escrita_valida = escrita_habilitada && (endereco_escrita != '0);

    // Register 0 is never written, so its cleared value doubles as the constant zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regs           <= '0;
            r_dado_depuracao <= '0;
            r_contador       <= '0;
        end else begin
            if (w_escrita_valida) begin
                r_regs[endereco_escrita] <= dado_escrita;
                r_contador               <= r_contador + 1'b1;
            end
            r_dado_depuracao <= r_regs[endereco_depuracao];
        end
    end

    assign dado_depuracao    = r_dado_depuracao;
    assign contador_escritas = r_contador;

    porta_leitura_bypass #(.LARGURA_DADOS(LARGURA_DADOS), .NUM_REGS(NUM_REGS)) u_porta_a (
        .i_reset_n          (reset_n),
        .i_regs             (r_regs),
        .i_escrita_valida   (w_escrita_valida),
        .i_endereco_escrita (endereco_escrita),
        .i_dado_escrita     (dado_escrita),
        .i_endereco_leitura (endereco_leitura_a),
        .o_dado_leitura     (dado_leitura_a)
    );

    porta_leitura_bypass #(.LARGURA_DADOS(LARGURA_DADOS), .NUM_REGS(NUM_REGS)) u_porta_b (
        .i_reset_n          (reset_n),
        .i_regs             (r_regs),
        .i_escrita_valida   (w_escrita_valida),
        .i_endereco_escrita (endereco_escrita),
        .i_dado_escrita     (dado_escrita),
        .i_endereco_leitura (endereco_leitura_b),
        .o_dado_leitura     (dado_leitura_b)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Directed self-checking bench for banco_registradores with hand-computed expectations.
module tb_banco_registradores;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  endereco_escrita = '0;
    logic [31:0] dado_escrita = '0;
    logic        escrita_habilitada = 1'b0;
    logic [4:0]  endereco_leitura_a = '0;
    logic [4:0]  endereco_leitura_b = '0;
    logic [31:0] dado_leitura_a, dado_leitura_b;
    logic [4:0]  endereco_depuracao = '0;
    logic [31:0] dado_depuracao;
    logic [15:0] contador_escritas;

    int n_checks = 0;
    int n_fails  = 0;

    banco_registradores dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .endereco_escrita   (endereco_escrita),
        .dado_escrita       (dado_escrita),
        .escrita_habilitada (escrita_habilitada),
        .endereco_leitura_a (endereco_leitura_a),
        .endereco_leitura_b (endereco_leitura_b),
        .dado_leitura_a     (dado_leitura_a),
        .dado_leitura_b     (dado_leitura_b),
        .endereco_depuracao (endereco_depuracao),
        .dado_depuracao     (dado_depuracao),
        .contador_escritas  (contador_escritas)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic escreve(input logic [4:0] a, input logic [31:0] d);
        escrita_habilitada = 1'b1;
        endereco_escrita   = a;
        dado_escrita       = d;
        tick();
        escrita_habilitada = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        verifica("rst_cnt", {16'h0, contador_escritas}, 32'h0);
        verifica("rst_dbg", dado_depuracao, 32'h0);
        verifica("rst_a", dado_leitura_a, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;

        // Write r5, read it back next cycle
        escreve(5'd5, 32'hDEADBEEF);
        endereco_leitura_a = 5'd5;
        #1;
        verifica("r5_a", dado_leitura_a, 32'hDEADBEEF);
        verifica("r5_cnt", {16'h0, contador_escritas}, 32'd1);

        // Write to r0 is discarded
        escrita_habilitada = 1'b1;
        endereco_escrita = 5'd0;
        dado_escrita = 32'h12345678;
        endereco_leitura_a = 5'd0;
        endereco_leitura_b = 5'd0;
        #1;
        verifica("r0_a_byp", dado_leitura_a, 32'h0);
        verifica("r0_b_byp", dado_leitura_b, 32'h0);
        tick();
        escrita_habilitada = 1'b0;
        #1;
        verifica("r0_a", dado_leitura_a, 32'h0);
        verifica("r0_cnt", {16'h0, contador_escritas}, 32'd1);

        // Bypass on both ports, debug lags by one cycle after the commit
        endereco_depuracao = 5'd7;
        tick();
        escrita_habilitada = 1'b1;
        endereco_escrita = 5'd7;
        dado_escrita = 32'hCAFEF00D;
        endereco_leitura_a = 5'd7;
        endereco_leitura_b = 5'd7;
        #1;
        verifica("byp_a", dado_leitura_a, 32'hCAFEF00D);
        verifica("byp_b", dado_leitura_b, 32'hCAFEF00D);
        verifica("dbg_old", dado_depuracao, 32'h0);
        tick();
        escrita_habilitada = 1'b0;
        verifica("dbg_commit_edge", dado_depuracao, 32'h0);
        verifica("r7_stored_a", dado_leitura_a, 32'hCAFEF00D);
        tick();
        verifica("dbg_new", dado_depuracao, 32'hCAFEF00D);
        verifica("r7_cnt", {16'h0, contador_escritas}, 32'd2);

        // Write enable low: nothing changes regardless of address/data
        for (int i = 0; i < 10; i++) begin
            endereco_escrita = 5'(i * 3 + 1);
            dado_escrita = 32'hA5A50000 + i;
            endereco_leitura_a = 5'd5;
            endereco_leitura_b = 5'(i * 3 + 1);
            tick();
        end
        verifica("idle_cnt", {16'h0, contador_escritas}, 32'd2);
        verifica("idle_r5", dado_leitura_a, 32'hDEADBEEF);
        verifica("idle_r28", dado_leitura_b, 32'h0);
        verifica("idle_dbg", dado_depuracao, 32'hCAFEF00D);

        // Consecutive writes to one address: last wins
        escrita_habilitada = 1'b1;
        endereco_escrita = 5'd9;
        dado_escrita = 32'h11111111;
        tick();
        dado_escrita = 32'h22222222;
        tick();
        escrita_habilitada = 1'b0;
        endereco_leitura_a = 5'd9;
        #1;
        verifica("last_wins", dado_leitura_a, 32'h22222222);
        verifica("last_cnt", {16'h0, contador_escritas}, 32'd4);

        // Fill r1..r31 with their index, then reset mid-cycle
        for (int i = 1; i < 32; i++) escreve(5'(i), 32'(i));
        endereco_leitura_a = 5'd31;
        endereco_leitura_b = 5'd17;
        endereco_depuracao = 5'd12;
        tick();
        verifica("fill_a", dado_leitura_a, 32'd31);
        verifica("fill_b", dado_leitura_b, 32'd17);
        verifica("fill_dbg", dado_depuracao, 32'd12);
        verifica("fill_cnt", {16'h0, contador_escritas}, 32'd35);
        escrita_habilitada = 1'b1;
        endereco_escrita = 5'd3;
        dado_escrita = 32'h000000AA;
        endereco_leitura_a = 5'd3;
        #1;
        verifica("pre_rst_byp", dado_leitura_a, 32'h000000AA);
        reset_n = 1'b0;
        #1;
        verifica("rst_byp_a", dado_leitura_a, 32'h0);
        verifica("rst_b", dado_leitura_b, 32'h0);
        verifica("rst_dbg2", dado_depuracao, 32'h0);
        verifica("rst_cnt2", {16'h0, contador_escritas}, 32'h0);
        tick();
        #2;
        reset_n = 1'b1;
        escrita_habilitada = 1'b0;
        #1;
        verifica("rst_lost_r3", dado_leitura_a, 32'h0);
        escreve(5'd9, 32'h00000099);
        endereco_leitura_a = 5'd9;
        #1;
        verifica("post_rst_wr", dado_leitura_a, 32'h00000099);
        verifica("post_rst_cnt", {16'h0, contador_escritas}, 32'd1);

        // Counter wrap: reset, then 65536 writes to r1
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        escrita_habilitada = 1'b1;
        endereco_escrita = 5'd1;
        for (int i = 0; i < 65535; i++) begin
            dado_escrita = 32'h00010000 + i;
            tick();
        end
        verifica("cnt_ffff", {16'h0, contador_escritas}, 32'h0000FFFF);
        dado_escrita = 32'h0001FFFF;
        tick();
        escrita_habilitada = 1'b0;
        endereco_leitura_a = 5'd1;
        #1;
        verifica("cnt_wrap", {16'h0, contador_escritas}, 32'h0);
        verifica("wrap_r1", dado_leitura_a, 32'h0001FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end before 2000000");
        $fatal(1, "timeout");
    end
endmodule
